na_reactor_sequencer: RTL and testbench

- Timed FSM that drives the valve-control and pump lines of the two-lane nucleic-acid reactor array.
- Runs one extraction: load lysate, mix on the peristaltic loop, trap beads, repeated wash, elute to collection.
- Sits between the host command interface and the valve-control nets. Both reactor lanes share every control line, so one sequencer drives both.

---
 rtl/na_reactor_sequencer_if.sv | 38 +++
 rtl/na_reactor_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_na_reactor_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/na_reactor_sequencer_if.sv
// na_reactor_sequencer_if
// Host-side command/status bundle and valve-control lines of the
// two-lane nucleic-acid reactor sequencer.
//   master : host / bench side (drives start, abort, durations, wash_reps)
//   slave  : sequencer side   (drives valves, pumps, busy, done, aborted, phase)
interface na_reactor_sequencer_if #(
  parameter int CNT_W      = 16,
  parameter int WASH_MAX_W = 3
);
  logic                  start;
  logic                  abort;
  logic [CNT_W-1:0]      t_load;
  logic [CNT_W-1:0]      t_mix;
  logic [CNT_W-1:0]      t_trap;
  logic [CNT_W-1:0]      t_wash;
  logic [CNT_W-1:0]      t_elute;
  logic [WASH_MAX_W-1:0] wash_reps;

  logic lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl;
  logic loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl;
  logic pump1, pump2, pump3;
  logic busy, done, aborted;
  logic [2:0] phase;

  modport master (
    output start, abort, t_load, t_mix, t_trap, t_wash, t_elute, wash_reps,
    input  lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl,
           loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl,
           pump1, pump2, pump3, busy, done, aborted, phase
  );

  modport slave (
    input  start, abort, t_load, t_mix, t_trap, t_wash, t_elute, wash_reps,
    output lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl,
           loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl,
           pump1, pump2, pump3, busy, done, aborted, phase
  );
endinterface

// File: rtl/na_reactor_sequencer.sv
// na_reactor_sequencer
// Timed sequencer for one extraction run on the two-lane reactor array:
// load lysate, mix on the peristaltic loop, trap beads, wash N times, elute.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : na_reactor_sequencer_if.slave (commands in; valves, pumps,
//                busy/done/aborted/phase out). All outputs are registered.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE  0 | waiting for start, all valves closed
// LOAD  1 | lysate in: lysis + vertical
// MIX   2 | horizontal loop with rotating pump pattern
// TRAP  3 | loop exit, bead vertical, bead trap
// WASH  4 | wash + bead trap + vertical, repeated wash_reps times
// ELUTE 5 | elute + vertical + bead trap + collection
// DONE  6 | one-cycle completion, done=1
module na_reactor_sequencer #(
  parameter int CNT_W      = 16,
  parameter int PUMP_DIV   = 4,
  parameter int WASH_MAX_W = 3
) (
  input  logic clk,
  input  logic rst_n,
  na_reactor_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_MIX   = 3'd2;
  localparam logic [2:0] S_TRAP  = 3'd3;
  localparam logic [2:0] S_WASH  = 3'd4;
  localparam logic [2:0] S_ELUTE = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam int DIV_W = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TOP = DIV_W'(PUMP_DIV - 1);

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WASH_MAX_W-1:0] wash_left_q, wash_left_d;
  logic                  gap_q, gap_d;
  logic [2:0]            pstep_q, pstep_d;
  logic [DIV_W-1:0]      pdiv_q, pdiv_d;
  logic                  latch_en, aborted_d, expired;

  logic [CNT_W-1:0]      lt_mix, lt_trap, lt_wash, lt_elute;
  logic [WASH_MAX_W-1:0] lt_reps;

  logic [11:0] valves_q;
  logic [2:0]  phase_q;
  logic        busy_q, done_q, aborted_q;

  // Reload value for a phase of length max(n,1): counter runs n-1 .. 0.
  function automatic logic [CNT_W-1:0] reload(input logic [CNT_W-1:0] n);
    return (n == '0) ? '0 : n - CNT_W'(1);
  endfunction

  function automatic logic [2:0] pump_bits(input logic [2:0] step);
    logic [2:0] p;
    case (step)
      3'd0:    p = 3'b100;
      3'd1:    p = 3'b110;
      3'd2:    p = 3'b010;
      3'd3:    p = 3'b011;
      3'd4:    p = 3'b001;
      3'd5:    p = 3'b101;
      default: p = 3'b000;
    endcase
    return p;
  endfunction

  // Bit order: lysis, wash, elute, horiz, vertical, loop_exit, bead_vtl,
  // bead_trap, collection, pump1, pump2, pump3. A gap cycle closes everything.
  function automatic logic [11:0] valve_set(input logic [2:0] st, input logic gap,
                                            input logic [2:0] step);
    logic [11:0] v;
    v = '0;
    if (!gap) begin
      case (st)
        S_LOAD:  v = 12'b1000_1000_0000;
        S_MIX:   v = 12'b0001_0000_0000 | {9'd0, pump_bits(step)};
        S_TRAP:  v = 12'b0000_0111_0000;
        S_WASH:  v = 12'b0100_1001_0000;
        S_ELUTE: v = 12'b0010_1001_1000;
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  assign expired = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wash_left_d = wash_left_q;
    gap_d       = 1'b0;
    pstep_d     = pstep_q;
    pdiv_d      = pdiv_q;
    latch_en    = 1'b0;
    aborted_d   = 1'b0;

    // Pump step counter runs on its own divider; the entry gap cycle
    // primes it so the first visible step is 100 held for PUMP_DIV cycles.
    if (state_q == S_MIX) begin
      if (gap_q) begin
        pstep_d = 3'd0;
        pdiv_d  = DIV_TOP;
      end else if (pdiv_q == '0) begin
        pstep_d = (pstep_q == 3'd5) ? 3'd0 : pstep_q + 3'd1;
        pdiv_d  = DIV_TOP;
      end else begin
        pdiv_d  = pdiv_q - DIV_W'(1);
      end
    end

    if (state_q != S_IDLE && bus.abort) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start) begin
          state_d  = S_LOAD;
          cnt_d    = reload(bus.t_load);
          latch_en = 1'b1;
        end
        S_LOAD: if (expired) begin
          state_d = S_MIX;
          cnt_d   = reload(lt_mix);
          gap_d   = 1'b1;
        end else cnt_d = cnt_q - CNT_W'(1);
        S_MIX: if (expired) begin
          state_d = S_TRAP;
          cnt_d   = reload(lt_trap);
          gap_d   = 1'b1;
        end else cnt_d = cnt_q - CNT_W'(1);
        S_TRAP: if (expired) begin
          gap_d = 1'b1;
          if (lt_reps == '0) begin
            state_d = S_ELUTE;
            cnt_d   = reload(lt_elute);
          end else begin
            state_d     = S_WASH;
            cnt_d       = reload(lt_wash);
            wash_left_d = lt_reps - WASH_MAX_W'(1);
          end
        end else cnt_d = cnt_q - CNT_W'(1);
        // Re-entering WASH keeps the same valve set, so no gap there.
        S_WASH: if (expired) begin
          if (wash_left_q == '0) begin
            state_d = S_ELUTE;
            cnt_d   = reload(lt_elute);
            gap_d   = 1'b1;
          end else begin
            cnt_d       = reload(lt_wash);
            wash_left_d = wash_left_q - WASH_MAX_W'(1);
          end
        end else cnt_d = cnt_q - CNT_W'(1);
        S_ELUTE: if (expired) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else cnt_d = cnt_q - CNT_W'(1);
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wash_left_q <= '0;
      gap_q       <= 1'b0;
      pstep_q     <= '0;
      pdiv_q      <= '0;
      lt_mix      <= '0;
      lt_trap     <= '0;
      lt_wash     <= '0;
      lt_elute    <= '0;
      lt_reps     <= '0;
      valves_q    <= '0;
      phase_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wash_left_q <= wash_left_d;
      gap_q       <= gap_d;
      pstep_q     <= pstep_d;
      pdiv_q      <= pdiv_d;
      if (latch_en) begin
        lt_mix   <= bus.t_mix;
        lt_trap  <= bus.t_trap;
        lt_wash  <= bus.t_wash;
        lt_elute <= bus.t_elute;
        lt_reps  <= bus.wash_reps;
      end
      // Outputs are registered from the next-state view so they line up
      // with the state register.
      valves_q  <= valve_set(state_d, gap_d, pstep_d);
      phase_q   <= state_d;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
      aborted_q <= aborted_d;
    end
  end

  assign {bus.lysis_ctl, bus.wash_ctl, bus.elute_ctl, bus.horiz_ctl,
          bus.vertical_ctl, bus.loop_exit_ctl, bus.bead_vtl_ctl,
          bus.bead_trap_ctl, bus.collection_ctl,
          bus.pump1, bus.pump2, bus.pump3} = valves_q;
  assign bus.phase   = phase_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.aborted = aborted_q;

endmodule

// File: tb/tb_na_reactor_sequencer.sv
module tb_na_reactor_sequencer;
  localparam int PUMP_DIV = 4;

  localparam logic [11:0] M_LYSIS = 12'h800, M_WASH  = 12'h400, M_ELUTE = 12'h200;
  localparam logic [11:0] M_HORIZ = 12'h100, M_VERT  = 12'h080, M_LOOP  = 12'h040;
  localparam logic [11:0] M_BVTL  = 12'h020, M_BTRAP = 12'h010, M_COLL  = 12'h008;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int compared = 0;
  int mismatched = 0;

  na_reactor_sequencer_if #(.CNT_W(16), .WASH_MAX_W(3)) bus ();

  na_reactor_sequencer #(.CNT_W(16), .PUMP_DIV(PUMP_DIV), .WASH_MAX_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [11:0] dut_v;
  assign dut_v = {bus.lysis_ctl, bus.wash_ctl, bus.elute_ctl, bus.horiz_ctl,
                  bus.vertical_ctl, bus.loop_exit_ctl, bus.bead_vtl_ctl,
                  bus.bead_trap_ctl, bus.collection_ctl, bus.pump1, bus.pump2, bus.pump3};

  logic [11:0] pump_tbl [6] = '{12'h004, 12'h006, 12'h002, 12'h003, 12'h001, 12'h005};

  int          exp_phase  [$];
  logic [11:0] exp_valves [$];
  bit          exp_done   [$];

  function automatic int dur(input int n);
    return (n < 1) ? 1 : n;
  endfunction

  function automatic void push(input int p, input logic [11:0] v, input bit d);
    exp_phase.push_back(p);
    exp_valves.push_back(v);
    exp_done.push_back(d);
  endfunction

  // Reference trace: one entry per cycle after the start edge.
  function automatic void build_trace(input int tl, tm, tt, tw, te, reps);
    exp_phase.delete(); exp_valves.delete(); exp_done.delete();
    for (int k = 0; k < dur(tl); k++) push(1, M_LYSIS | M_VERT, 0);
    for (int k = 0; k < dur(tm); k++)
      push(2, (k == 0) ? 12'h000 : (M_HORIZ | pump_tbl[((k - 1) / PUMP_DIV) % 6]), 0);
    for (int k = 0; k < dur(tt); k++) push(3, (k == 0) ? 12'h000 : (M_LOOP | M_BVTL | M_BTRAP), 0);
    for (int r = 0; r < reps; r++)
      for (int k = 0; k < dur(tw); k++)
        push(4, (r == 0 && k == 0) ? 12'h000 : (M_WASH | M_BTRAP | M_VERT), 0);
    for (int k = 0; k < dur(te); k++)
      push(5, (k == 0) ? 12'h000 : (M_ELUTE | M_VERT | M_BTRAP | M_COLL), 0);
    push(6, 12'h000, 1);
  endfunction

  task automatic drive_cfg(input int tl, tm, tt, tw, te, reps);
    bus.t_load = 16'(tl); bus.t_mix = 16'(tm); bus.t_trap = 16'(tt);
    bus.t_wash = 16'(tw); bus.t_elute = 16'(te); bus.wash_reps = 3'(reps);
  endtask

  task automatic run_seq(input string name, input int tl, tm, tt, tw, te, reps,
                         input int abort_at, input bit perturb,
                         output int done_cnt, output int wash_cnt);
    int n;
    done_cnt = 0; wash_cnt = 0;
    build_trace(tl, tm, tt, tw, te, reps);
    n = exp_phase.size();
    drive_cfg(tl, tm, tt, tw, te, reps);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      compared++;
      if (bus.phase !== 3'(exp_phase[i])) begin
        mismatched++; $display("FAIL %s phase cyc%0d got %0d want %0d", name, i, bus.phase, exp_phase[i]);
      end
      compared++;
      if (dut_v !== exp_valves[i]) begin
        mismatched++; $display("FAIL %s valves cyc%0d got %h want %h", name, i, dut_v, exp_valves[i]);
      end
      compared++;
      if (bus.done !== exp_done[i]) begin
        mismatched++; $display("FAIL %s done cyc%0d got %b want %b", name, i, bus.done, exp_done[i]);
      end
      compared++;
      if (bus.busy !== 1'b1 || bus.aborted !== 1'b0) begin
        mismatched++; $display("FAIL %s busy/aborted cyc%0d got %b/%b want 1/0", name, i, bus.busy, bus.aborted);
      end
      if (bus.done === 1'b1) done_cnt++;
      if (bus.wash_ctl === 1'b1) wash_cnt++;
      if (i == abort_at) begin
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        compared++;
        if (bus.phase !== 3'd0 || dut_v !== 12'h000 || bus.aborted !== 1'b1 ||
            bus.done !== 1'b0 || bus.busy !== 1'b0) begin
          mismatched++;
          $display("FAIL %s abort_cycle phase=%0d valves=%h aborted=%b done=%b busy=%b want 0/000/1/0/0",
                   name, bus.phase, dut_v, bus.aborted, bus.done, bus.busy);
        end
        @(posedge clk); #1;
        compared++;
        if (bus.aborted !== 1'b0 || bus.done !== 1'b0 || bus.phase !== 3'd0) begin
          mismatched++;
          $display("FAIL %s abort_after aborted=%b done=%b phase=%0d want 0/0/0", name, bus.aborted, bus.done, bus.phase);
        end
        return;
      end
      if (perturb && i < n - 1) begin
        drive_cfg($urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 40),
                  $urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 7));
        bus.start = 1'($urandom_range(0, 1));
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    compared++;
    if (bus.phase !== 3'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || dut_v !== 12'h000) begin
      mismatched++;
      $display("FAIL %s end_idle phase=%0d busy=%b done=%b valves=%h want 0/0/0/000", name, bus.phase, bus.busy, bus.done, dut_v);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.abort = 1'b0;
    drive_cfg(3, 3, 3, 3, 3, 2);
    rst_n = 1'b0;
    #12;
    compared++;
    if (dut_v !== 12'h000 || bus.phase !== 3'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.aborted !== 1'b0) begin
      mismatched++; $display("FAIL reset_state valves=%h phase=%0d busy=%b done=%b aborted=%b want all 0",
                             dut_v, bus.phase, bus.busy, bus.done, bus.aborted);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (bus.busy !== 1'b0 || bus.phase !== 3'd0) begin
      mismatched++; $display("FAIL reset_release busy=%b phase=%0d want 0/0", bus.busy, bus.phase);
    end
  endtask

  task automatic test_nominal();
    int dc, wc;
    run_seq("nominal", 3, 3, 3, 3, 3, 2, -1, 0, dc, wc);
    compared++;
    if (dc != 1) begin mismatched++; $display("FAIL nominal done_count got %0d want 1", dc); end
  endtask

  task automatic test_pump();
    int dc, wc;
    run_seq("pump", 2, 30, 2, 2, 2, 1, -1, 0, dc, wc);
  endtask

  task automatic test_no_wash();
    int dc, wc;
    run_seq("no_wash", 0, 2, 2, 2, 2, 0, -1, 0, dc, wc);
    compared++;
    if (wc != 0) begin mismatched++; $display("FAIL no_wash wash_ctl_cycles got %0d want 0", wc); end
  endtask

  task automatic test_abort();
    int dc, wc;
    run_seq("abort", 3, 3, 3, 3, 3, 2, 3 + 3 + 3 + 3 + 1, 0, dc, wc);
    compared++;
    if (dc != 0) begin mismatched++; $display("FAIL abort done_count got %0d want 0", dc); end
    run_seq("after_abort", 3, 3, 3, 3, 3, 2, -1, 0, dc, wc);
  endtask

  task automatic test_start_ignored();
    int dc, wc;
    run_seq("restart_ignored", 2, 6, 2, 3, 2, 2, -1, 1, dc, wc);
    compared++;
    if (dc != 1) begin mismatched++; $display("FAIL restart_ignored done_count got %0d want 1", dc); end
  endtask

  task automatic test_async_reset();
    int idx;
    build_trace(2, 2, 2, 2, 4, 1);
    idx = 2 + 2 + 2 + 2 + 2;
    drive_cfg(2, 2, 2, 2, 4, 1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < idx; i++) begin @(posedge clk); #1; end
    compared++;
    if (bus.phase !== 3'd5 || dut_v !== exp_valves[idx]) begin
      mismatched++; $display("FAIL areset_pre phase=%0d valves=%h want 5/%h", bus.phase, dut_v, exp_valves[idx]);
    end
    #3 rst_n = 1'b0;
    #1;
    compared++;
    if (dut_v !== 12'h000 || bus.phase !== 3'd0 || bus.busy !== 1'b0) begin
      mismatched++; $display("FAIL areset_now valves=%h phase=%0d busy=%b want 000/0/0", dut_v, bus.phase, bus.busy);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      compared++;
      if (bus.busy !== 1'b0 || bus.phase !== 3'd0 || dut_v !== 12'h000) begin
        mismatched++; $display("FAIL areset_idle cyc%0d busy=%b phase=%0d valves=%h want 0/0/000", i, bus.busy, bus.phase, dut_v);
      end
    end
  endtask

  task automatic test_random();
    int dc, wc, tl, tm, tt, tw, te, reps, n, ab;
    for (int r = 0; r < 12; r++) begin
      tl = $urandom_range(0, 5); tm = $urandom_range(0, 14); tt = $urandom_range(0, 5);
      tw = $urandom_range(0, 5); te = $urandom_range(0, 5); reps = $urandom_range(0, 3);
      n = dur(tl) + dur(tm) + dur(tt) + reps * dur(tw) + dur(te) + 1;
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 2) : -1;
      run_seq("random", tl, tm, tt, tw, te, reps, ab, 1'($urandom_range(0, 1)), dc, wc);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_nominal();
    test_pump();
    test_no_wash();
    test_abort();
    test_start_ignored();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
